// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared RV32I type package for the pipeline.
//   load_funct3_t      : funct3 encodings of the load instructions
//   store_funct3_t     : funct3 encodings of the store instructions
//   mem_stage_state_t  : memory-access stage FSM states
//   is_misaligned()    : access-size alignment check shared by loads/stores
// -----------------------------------------------------------------------------
package rv32i_types;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } mem_stage_state_t;

   // funct3[1:0] encodes access size for both loads and stores
   // (00 byte, 01 half, 10 word), so one check covers lh/lhu/sh and lw/sw.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (funct3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_stage_store_aligner.sv
// -----------------------------------------------------------------------------
// store_aligner
// Combinational store lane steering for the memory-access stage.
//   funct3_i      in  3   load/store funct3
//   addr_lo_i     in  2   effective address bits [1:0]
//   rs2_i         in  32  unshifted store data
//   byte_enable_o out 4   store byte mask
//   wdata_o       out 32  store data shifted into its byte lanes
//   misaligned_o  out 1   access is not naturally aligned for its size
// -----------------------------------------------------------------------------
module store_aligner
   import rv32i_types::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rs2_i,
   output logic [3:0]  byte_enable_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o
);

   always_comb begin
      byte_enable_o = 4'b0000;
      wdata_o       = rs2_i << {addr_lo_i, 3'b000};
      case (funct3_i)
         sb:      byte_enable_o = 4'b0001 << addr_lo_i;
         sh:      byte_enable_o = 4'b0011 << addr_lo_i;
         sw: begin
            byte_enable_o = 4'b1111;
            wdata_o       = rs2_i;
         end
         default: byte_enable_o = 4'b0000;
      endcase
   end

   assign misaligned_o = is_misaligned(funct3_i, addr_lo_i);

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the 5-stage RV32I pipeline. Issues one data-memory request per
// load/store with a request/response handshake, stalls the pipeline while the
// request is outstanding, and captures the raw read word for MEM/WB.
//   clk, rst          clock, asynchronous active-high reset
//   valid_in          EX/MEM holds a live instruction
//   mem_read_in       load
//   mem_write_in      store (wins over mem_read_in)
//   funct3_in         load/store funct3
//   alu_data_in       effective address
//   rs2_data_in       unshifted store data
//   dmem_*            registered memory request port, dmem_rdata/dmem_resp in
//   stall_out         hold the upstream pipeline registers
//   read_data_out     captured read word
//   address_out       effective address passthrough
//   misaligned_out    current memory instruction is misaligned and dropped
// -----------------------------------------------------------------------------
module mem_access_stage
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] alu_data_in,
   input  logic [31:0] rs2_data_in,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [31:0] dmem_address,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_byte_enable,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        stall_out,
   output logic [31:0] read_data_out,
   output logic [31:0] address_out,
   output logic        misaligned_out
);

   mem_stage_state_t state_q, state_d;

   logic        dmem_read_q;
   logic        dmem_write_q;
   logic [31:0] dmem_address_q;
   logic [31:0] dmem_wdata_q;
   logic [3:0]  dmem_byte_enable_q;
   logic [31:0] read_data_q;

   logic [3:0]  align_be;
   logic [31:0] align_wdata;
   logic        align_misaligned;

   logic        mem_op;
   logic        start;

   store_aligner u_store_aligner (
      .funct3_i      (funct3_in),
      .addr_lo_i     (alu_data_in[1:0]),
      .rs2_i         (rs2_data_in),
      .byte_enable_o (align_be),
      .wdata_o       (align_wdata),
      .misaligned_o  (align_misaligned)
   );

   assign mem_op = valid_in & (mem_read_in | mem_write_in);
   // Misaligned ops never leave IDLE, so they cost no cycles and no request.
   assign start  = (state_q == IDLE) & mem_op & ~align_misaligned;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ACCESS;
         ACCESS:  if (dmem_resp) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // DONE releases the stall so EX/MEM advances exactly once per op.
   always_comb begin
      stall_out = 1'b0;
      case (state_q)
         IDLE:    stall_out = start;
         ACCESS:  stall_out = 1'b1;
         default: stall_out = 1'b0;
      endcase
   end

   // ---------------- request and read-data registers ----------------
   // Request fields are loaded on IDLE->ACCESS, held through ACCESS and
   // cleared on the response, so the port is idle in IDLE and DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_read_q        <= 1'b0;
         dmem_write_q       <= 1'b0;
         dmem_address_q     <= 32'h0;
         dmem_wdata_q       <= 32'h0;
         dmem_byte_enable_q <= 4'b0000;
         read_data_q        <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  dmem_read_q        <= mem_read_in & ~mem_write_in;
                  dmem_write_q       <= mem_write_in;
                  dmem_address_q     <= {alu_data_in[31:2], 2'b00};
                  dmem_wdata_q       <= mem_write_in ? align_wdata : 32'h0;
                  dmem_byte_enable_q <= mem_write_in ? align_be : 4'b0000;
               end
            end
            ACCESS: begin
               if (dmem_resp) begin
                  if (dmem_read_q) begin
                     read_data_q <= dmem_rdata;
                  end
                  dmem_read_q        <= 1'b0;
                  dmem_write_q       <= 1'b0;
                  dmem_address_q     <= 32'h0;
                  dmem_wdata_q       <= 32'h0;
                  dmem_byte_enable_q <= 4'b0000;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dmem_read        = dmem_read_q;
   assign dmem_write       = dmem_write_q;
   assign dmem_address     = dmem_address_q;
   assign dmem_wdata       = dmem_wdata_q;
   assign dmem_byte_enable = dmem_byte_enable_q;
   assign read_data_out    = read_data_q;
   assign address_out      = alu_data_in;
   assign misaligned_out   = mem_op & align_misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, mem_read_in, mem_write_in;
   logic [2:0]  funct3_in;
   logic [31:0] alu_data_in, rs2_data_in;
   logic        dmem_read, dmem_write;
   logic [31:0] dmem_address, dmem_wdata;
   logic [3:0]  dmem_byte_enable;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        stall_out;
   logic [31:0] read_data_out, address_out;
   logic        misaligned_out;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk              (clk),
      .rst              (rst),
      .valid_in         (valid_in),
      .mem_read_in      (mem_read_in),
      .mem_write_in     (mem_write_in),
      .funct3_in        (funct3_in),
      .alu_data_in      (alu_data_in),
      .rs2_data_in      (rs2_data_in),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_address     (dmem_address),
      .dmem_wdata       (dmem_wdata),
      .dmem_byte_enable (dmem_byte_enable),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp),
      .stall_out        (stall_out),
      .read_data_out    (read_data_out),
      .address_out      (address_out),
      .misaligned_out   (misaligned_out)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] r);
      valid_in     = v;
      mem_read_in  = rd;
      mem_write_in = wr;
      funct3_in    = f3;
      alu_data_in  = a;
      rs2_data_in  = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        valid, rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, rs2, rdata;
      logic        exp_mis, exp_go;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata, exp_daddr;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] r, input logic [31:0] rdat,
                               input logic mis, input logic go, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] da);
      vec_t t;
      t.valid = v; t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = a; t.rs2 = r; t.rdata = rdat;
      t.exp_mis = mis; t.exp_go = go; t.exp_be = be; t.exp_wdata = wd; t.exp_daddr = da;
      return t;
   endfunction

   localparam int NV = 16;
   vec_t vecs [NV];
   logic [31:0] exp_rdata;
   int stall_hi, read_hi;

   initial begin
      //              v  rd wr f3      addr          rs2           rdata         mis go be     wdata         daddr
      vecs[0]  = mk(1, 0, 1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        0, 1, 4'hF, 32'hDEADBEEF, 32'h100);
      vecs[1]  = mk(1, 0, 1, 3'b000, 32'h0000_0203, 32'h000000AB, 32'h0,        0, 1, 4'h8, 32'hAB000000, 32'h200);
      vecs[2]  = mk(1, 0, 1, 3'b000, 32'h0000_0201, 32'h123456CD, 32'h0,        0, 1, 4'h2, 32'h3456CD00, 32'h200);
      vecs[3]  = mk(1, 0, 1, 3'b001, 32'h0000_0302, 32'hCAFEBABE, 32'h0,        0, 1, 4'hC, 32'hBABE0000, 32'h300);
      vecs[4]  = mk(1, 0, 1, 3'b001, 32'h0000_0300, 32'h0000BEEF, 32'h0,        0, 1, 4'h3, 32'h0000BEEF, 32'h300);
      vecs[5]  = mk(1, 0, 1, 3'b001, 32'h0000_0301, 32'h11111111, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0);
      vecs[6]  = mk(1, 0, 1, 3'b010, 32'h0000_0102, 32'h22222222, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0);
      vecs[7]  = mk(1, 1, 0, 3'b010, 32'h0000_0040, 32'h0,        32'h12345678, 0, 1, 4'h0, 32'h0,        32'h40);
      vecs[8]  = mk(1, 1, 0, 3'b100, 32'h0000_0043, 32'h0,        32'hA5A5A5A5, 0, 1, 4'h0, 32'h0,        32'h40);
      vecs[9]  = mk(1, 1, 0, 3'b001, 32'h0000_0041, 32'h0,        32'h33333333, 1, 0, 4'h0, 32'h0,        32'h0);
      vecs[10] = mk(1, 1, 0, 3'b101, 32'h0000_0046, 32'h0,        32'h0BADF00D, 0, 1, 4'h0, 32'h0,        32'h44);
      vecs[11] = mk(1, 1, 0, 3'b010, 32'h0000_0045, 32'h0,        32'h44444444, 1, 0, 4'h0, 32'h0,        32'h0);
      vecs[12] = mk(1, 0, 0, 3'b010, 32'h0000_0055, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0);
      vecs[13] = mk(0, 1, 0, 3'b010, 32'h0000_0041, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0);
      vecs[14] = mk(1, 1, 1, 3'b010, 32'h0000_0080, 32'h11223344, 32'h55555555, 0, 1, 4'hF, 32'h11223344, 32'h80);
      vecs[15] = mk(1, 0, 1, 3'b000, 32'h0000_0000, 32'hFFFFFF5A, 32'h0,        0, 1, 4'h1, 32'hFFFFFF5A, 32'h0);

      rst = 1'b1;
      dmem_resp = 1'b0;
      dmem_rdata = 32'h0;
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      exp_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      // ---------------- reset state ----------------
      chk1 ("rst_read",  dmem_read, 1'b0);
      chk1 ("rst_write", dmem_write, 1'b0);
      chk32("rst_addr",  dmem_address, 32'h0);
      chk32("rst_wdata", dmem_wdata, 32'h0);
      chk32("rst_be",    {28'h0, dmem_byte_enable}, 32'h0);
      chk32("rst_rdata", read_data_out, 32'h0);
      chk1 ("rst_stall", stall_out, 1'b0);
      $display("reset state checked");
      rst = 1'b0;
      tick();

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].rs2);
         dmem_rdata = vecs[i].rdata;
         #1;
         chk1 ($sformatf("v%0d_mis", i),   misaligned_out, vecs[i].exp_mis);
         chk1 ($sformatf("v%0d_stall0", i), stall_out, vecs[i].exp_go);
         chk32($sformatf("v%0d_addr_out", i), address_out, vecs[i].addr);
         tick();
         if (vecs[i].exp_go) begin
            chk1 ($sformatf("v%0d_read", i),  dmem_read, vecs[i].rd & ~vecs[i].wr);
            chk1 ($sformatf("v%0d_write", i), dmem_write, vecs[i].wr);
            chk32($sformatf("v%0d_daddr", i), dmem_address, vecs[i].exp_daddr);
            chk32($sformatf("v%0d_be", i),    {28'h0, dmem_byte_enable}, {28'h0, vecs[i].exp_be});
            if (vecs[i].wr)
               chk32($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
            chk1 ($sformatf("v%0d_stall1", i), stall_out, 1'b1);
            dmem_resp = 1'b1;
            tick();
            dmem_resp = 1'b0;
            dmem_rdata = 32'hFFFF_FFFF;
            if (vecs[i].rd && !vecs[i].wr) exp_rdata = vecs[i].rdata;
            chk1 ($sformatf("v%0d_done_stall", i), stall_out, 1'b0);
            chk1 ($sformatf("v%0d_done_read", i),  dmem_read, 1'b0);
            chk1 ($sformatf("v%0d_done_write", i), dmem_write, 1'b0);
            chk32($sformatf("v%0d_rdata", i), read_data_out, exp_rdata);
            tick();
         end else begin
            chk1 ($sformatf("v%0d_noreq_read", i),  dmem_read, 1'b0);
            chk1 ($sformatf("v%0d_noreq_write", i), dmem_write, 1'b0);
            chk1 ($sformatf("v%0d_noreq_stall", i), stall_out, 1'b0);
            chk1 ($sformatf("v%0d_noreq_mis", i),   misaligned_out, vecs[i].exp_mis);
            chk32($sformatf("v%0d_keep_rdata", i),  read_data_out, exp_rdata);
         end
         drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
         $display("vector %0d f3=%b addr=%h done (checks so far %0d)", i, vecs[i].f3, vecs[i].addr, checks);
      end

      // ---------------- sw with response on 2nd ACCESS cycle ----------------
      stall_hi = 0;
      drive(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF);
      #1;
      if (stall_out) stall_hi++;
      tick();                                   // ACCESS, no response
      chk1 ("sw2_write_a", dmem_write, 1'b1);
      if (stall_out) stall_hi++;
      tick();                                   // ACCESS again, fields held
      chk1 ("sw2_write_b", dmem_write, 1'b1);
      chk32("sw2_addr_b",  dmem_address, 32'h100);
      chk32("sw2_wdata_b", dmem_wdata, 32'hDEADBEEF);
      chk32("sw2_be_b",    {28'h0, dmem_byte_enable}, 32'hF);
      if (stall_out) stall_hi++;
      dmem_resp = 1'b1;
      tick();                                   // DONE
      dmem_resp = 1'b0;
      chk1 ("sw2_done_stall", stall_out, 1'b0);
      chk32("sw2_stall_cycles", stall_hi, 3);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      tick();
      $display("sw with one wait cycle: stall cycles %0d", stall_hi);

      // ---------------- response in IDLE is ignored ----------------
      dmem_resp = 1'b1;
      dmem_rdata = 32'h7777_7777;
      tick();
      dmem_resp = 1'b0;
      chk1 ("idle_resp_stall", stall_out, 1'b0);
      chk1 ("idle_resp_read",  dmem_read, 1'b0);
      chk32("idle_resp_rdata", read_data_out, exp_rdata);
      $display("stray response in IDLE");

      // ---------------- back-to-back lw then sw ----------------
      read_hi = 0;
      drive(1, 1, 0, 3'b010, 32'h60, 32'h0);
      #1;
      chk1("b2b_lw_stall0", stall_out, 1'b1);
      if (dmem_read) read_hi++;
      tick();                                   // ACCESS
      if (dmem_read) read_hi++;
      dmem_resp = 1'b1;
      dmem_rdata = 32'hFEEDFACE;
      tick();                                   // DONE
      dmem_resp = 1'b0;
      dmem_rdata = 32'h9999_9999;
      exp_rdata = 32'hFEEDFACE;
      if (dmem_read) read_hi++;
      chk1 ("b2b_lw_done_stall", stall_out, 1'b0);
      chk32("b2b_lw_rdata", read_data_out, exp_rdata);
      tick();                                   // instruction advanced: sw now in EX/MEM
      drive(1, 0, 1, 3'b010, 32'h64, 32'h55AA55AA);
      #1;
      if (dmem_read) read_hi++;
      chk1("b2b_sw_stall0", stall_out, 1'b1);
      chk1("b2b_sw_idle_write", dmem_write, 1'b0);
      tick();                                   // ACCESS for sw
      if (dmem_read) read_hi++;
      chk1 ("b2b_sw_write", dmem_write, 1'b1);
      chk32("b2b_sw_addr",  dmem_address, 32'h64);
      chk32("b2b_sw_wdata", dmem_wdata, 32'h55AA55AA);
      dmem_resp = 1'b1;
      tick();                                   // DONE
      dmem_resp = 1'b0;
      if (dmem_read) read_hi++;
      chk1 ("b2b_sw_done_stall", stall_out, 1'b0);
      chk32("b2b_keep_rdata", read_data_out, exp_rdata);
      chk32("b2b_read_cycles", read_hi, 1);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      tick();
      $display("back-to-back lw/sw: read cycles %0d", read_hi);

      // ---------------- asynchronous reset mid-ACCESS ----------------
      drive(1, 1, 0, 3'b010, 32'h20, 32'h0);
      tick();                                   // ACCESS
      chk1("rstm_read_before", dmem_read, 1'b1);
      #2;
      rst = 1'b1;
      #1;                                       // still before the next edge
      chk1("rstm_read_dropped", dmem_read, 1'b0);
      drive(1, 0, 0, 3'b000, 32'h1234, 32'h0);  // ALU-only instruction
      exp_rdata = 32'h0;
      #1;
      rst = 1'b0;
      #1;
      chk1("rstm_alu_stall", stall_out, 1'b0);
      tick();
      chk1 ("rstm_alu_stall_next", stall_out, 1'b0);
      chk1 ("rstm_alu_read", dmem_read, 1'b0);
      chk32("rstm_rdata", read_data_out, exp_rdata);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      $display("reset during ACCESS");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
